// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI RAM slave: command and FSM state encodings
// plus the address-width helper used by the top and the RAM.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_EXEC,
        ST_TX,
        ST_DONE
    } state_e;

    // Address width for a memory of the given depth, never below one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, W x MEM_DEPTH, one-cycle read latency.
// Writes outside the array are dropped; reads outside it return zero.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int W         = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = addr_width(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    logic [W-1:0] mem [MEM_DEPTH];
    logic [W-1:0] rdata_q;
    logic         in_range;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign rdata    = rdata_q;

    // Registered write and read of the single shared address port.
    // NOTE: the array is deliberately not reset; only control state clears.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
        rdata_q <= in_range ? mem[addr] : '0;
    end

endmodule

// File: rtl/spi_ram_slave.sv
// SPI-style RAM slave clocked directly by the serial bit clock.
// Frame: 2-bit command then W payload bits, MSB first, while ss_n is low.
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment wr_addr
// after each data write and rd_addr after each data read.
module spi_ram_slave
    import spi_ram_pkg::*;
#(
    parameter int W         = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic busy
);

    localparam int ADDR_W     = addr_width(MEM_DEPTH);
    localparam int FRAME_BITS = W + 2;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_RX   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  TX_BITS   = CNT_W'(W);

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [W-1:0]          tx_q, tx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic                  miso_q, miso_d;
    logic                  busy_q, busy_d;

    cmd_e                  cmd;
    logic [W-1:0]          payload;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [W-1:0]          mem_rdata;

    assign cmd     = cmd_e'(rx_q[FRAME_BITS-1:W]);
    assign payload = rx_q[W-1:0];
    assign miso    = miso_q;
    assign busy    = busy_q;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    spi_ram_mem #(
        .W         (W),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (payload),
        .rdata (mem_rdata)
    );

    // Next-state, datapath and memory-port decode for the frame FSM.
    always_comb begin
        // NOTE: every _d starts from its hold value so no path leaves a latch.
        state_d   = state_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        miso_d    = 1'b0;
        mem_we    = 1'b0;
        // The read port tracks rd_addr so the word is ready at the EXEC edge.
        mem_addr  = rd_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!ss_n) begin
                    rx_d    = '0;
                    rx_d[0] = mosi;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RX;
                end
            end

            ST_RX: begin
                if (ss_n) begin
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    rx_d = {rx_q[FRAME_BITS-2:0], mosi};
                    if (cnt_q == LAST_RX) begin
                        cnt_d   = '0;
                        state_d = ST_EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_EXEC: begin
                state_d = ST_DONE;
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr_d = payload[ADDR_W-1:0];
                    CMD_WR_DATA: begin
                        mem_we   = !rst;
                        mem_addr = wr_addr_q;
                        if (AUTOINC) wr_addr_d = next_addr(wr_addr_q);
                    end
                    CMD_RD_ADDR: rd_addr_d = payload[ADDR_W-1:0];
                    CMD_RD_DATA: begin
                        miso_d  = mem_rdata[W-1];
                        tx_d    = mem_rdata << 1;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_TX;
                        if (AUTOINC) rd_addr_d = next_addr(rd_addr_q);
                    end
                endcase
            end

            ST_TX: begin
                if (ss_n) begin
                    tx_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == TX_BITS) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    miso_d = tx_q[W-1];
                    tx_d   = tx_q << 1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (ss_n) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset wins over any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rx_q      <= '0;
            tx_q      <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q   <= state_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            miso_q    <= miso_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Bench for spi_ram_slave: two instances (depth 256 and depth 200) share
// the same serial stimulus; a transaction-level model predicts busy/miso.
module tb_spi_ram_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso_a, busy_a, miso_b, busy_b;

    always #5 clk = ~clk;

    spi_ram_slave #(.W(8), .MEM_DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso_a), .busy(busy_a)
    );

    spi_ram_slave #(.W(8), .MEM_DEPTH(200)) dut_b (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso_b), .busy(busy_b)
    );

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic exp_valid  = 1'b0;
    logic exp_busy   = 1'b0;
    logic exp_miso_a = 1'b0;
    logic exp_miso_b = 1'b0;

    // Model state: one memory image and address pair per instance.
    int         depth [2] = '{256, 200};
    logic [7:0] mem_m [2][256];
    int         wa [2];
    int         ra [2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model's prediction.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("busy_a", {7'd0, busy_a}, {7'd0, exp_busy});
            check("miso_a", {7'd0, miso_a}, {7'd0, exp_miso_a});
            check("busy_b", {7'd0, busy_b}, {7'd0, exp_busy});
            check("miso_b", {7'd0, miso_b}, {7'd0, exp_miso_b});
        end
    end

    function automatic int inc_addr(input int x, input int i);
        return (x == depth[i] - 1) ? 0 : (x + 1) % 256;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            wa[i] = 0;
            ra[i] = 0;
        end
    endfunction

    // One clock: drive inputs, state what both DUTs must show after the edge.
    task automatic step(input logic s, input logic m, input logic r,
                        input logic eb, input logic ema, input logic emb,
                        output logic oa, output logic ob, output logic obusy);
        ss_n = s;
        mosi = m;
        rst  = r;
        @(posedge clk);
        exp_busy   = eb;
        exp_miso_a = ema;
        exp_miso_b = emb;
        exp_valid  = 1'b1;
        @(negedge clk);
        #1;
        oa    = miso_a;
        ob    = miso_b;
        obusy = busy_a;
    endtask

    // One frame: nbits < 10 aborts early; otherwise ss_n stays low for
    // `hold` edges after the last bit; rst_at > 0 asserts rst on that hold edge.
    task automatic frame(input logic [1:0] cmd, input logic [7:0] pl,
                         input int nbits, input int hold, input int rst_at,
                         output logic [7:0] byte_a, output logic [7:0] byte_b,
                         output logic last_busy);
        logic [9:0] bits;
        logic [7:0] rd [2];
        logic oa, ob, bz;
        bits   = {cmd, pl};
        byte_a = '0;
        byte_b = '0;
        rd[0]  = '0;
        rd[1]  = '0;
        for (int i = 0; i < nbits; i++) begin
            step(1'b0, bits[9-i], 1'b0, 1'b1, 1'b0, 1'b0, oa, ob, bz);
        end
        if (nbits < 10) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, oa, ob, last_busy);
            return;
        end
        for (int x = 0; x < 2; x++) begin
            case (cmd)
                2'b00: wa[x] = pl;
                2'b01: begin
                    if (wa[x] < depth[x]) mem_m[x][wa[x]] = pl;
                    if (AUTOINC) wa[x] = inc_addr(wa[x], x);
                end
                2'b10: ra[x] = pl;
                default: begin
                    rd[x] = (ra[x] < depth[x]) ? mem_m[x][ra[x]] : 8'h00;
                    if (AUTOINC) ra[x] = inc_addr(ra[x], x);
                end
            endcase
        end
        for (int j = 1; j <= hold; j++) begin
            logic ema, emb;
            if (j == rst_at) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0, oa, ob, bz);
                check("rst_tx_miso", {7'd0, oa}, 8'h00);
                check("rst_tx_busy", {7'd0, bz}, 8'h00);
                model_reset();
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, oa, ob, last_busy);
                return;
            end
            ema = (cmd == 2'b11 && j <= 8) ? rd[0][8-j] : 1'b0;
            emb = (cmd == 2'b11 && j <= 8) ? rd[1][8-j] : 1'b0;
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, ema, emb, oa, ob, bz);
            if (j <= 8) begin
                byte_a[8-j] = oa;
                byte_b[8-j] = ob;
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, oa, ob, last_busy);
    endtask

    initial begin
        logic oa, ob, bz;
        logic [7:0] ba, bb;
        model_reset();

        // Reset, then a few idle cycles.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, oa, ob, bz);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, oa, ob, bz);
        check("reset_busy", {7'd0, bz}, 8'h00);
        check("reset_miso", {7'd0, oa}, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, oa, ob, bz);

        // Address load then data write, followed by a readback.
        frame(2'b00, 8'h12, 10, 1, 0, ba, bb, bz);
        frame(2'b01, 8'hA5, 10, 1, 0, ba, bb, bz);
        frame(2'b10, 8'h12, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 10, 0, ba, bb, bz);
        check("read_0x12", ba, 8'hA5);

        // Aborted write after 5 bits leaves memory untouched.
        frame(2'b01, 8'hFF, 5, 0, 0, ba, bb, bz);
        check("abort_busy", {7'd0, bz}, 8'h00);
        frame(2'b10, 8'h12, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 9, 0, ba, bb, bz);
        check("after_abort", ba, 8'hA5);

        // Seed mem[0], then reset during the third TX bit of a read.
        frame(2'b00, 8'h00, 10, 1, 0, ba, bb, bz);
        frame(2'b01, 8'h3C, 10, 3, 0, ba, bb, bz);
        frame(2'b10, 8'h12, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 5, 3, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 9, 0, ba, bb, bz);
        check("rd_addr_cleared", ba, 8'h3C);

        // Wrap of wr_addr at the top of the 256-word memory.
        frame(2'b00, 8'hFF, 10, 1, 0, ba, bb, bz);
        frame(2'b01, 8'h11, 10, 1, 0, ba, bb, bz);
        frame(2'b01, 8'h22, 10, 1, 0, ba, bb, bz);
        frame(2'b10, 8'hFF, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 9, 0, ba, bb, bz);
        check("wrap_mem_ff", ba, AUTOINC ? 8'h11 : 8'h22);
        frame(2'b10, 8'h00, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 9, 0, ba, bb, bz);
        check("wrap_mem_00", ba, AUTOINC ? 8'h22 : 8'h3C);

        // Out-of-range address on the 200-word instance.
        frame(2'b00, 8'hD0, 10, 1, 0, ba, bb, bz);
        frame(2'b01, 8'h5A, 10, 1, 0, ba, bb, bz);
        frame(2'b10, 8'hD0, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 9, 0, ba, bb, bz);
        check("d0_depth256", ba, 8'h5A);
        check("d0_depth200", bb, 8'h00);

        // Bits clocked in while in DONE are ignored.
        frame(2'b00, 8'h40, 10, 12, 0, ba, bb, bz);
        frame(2'b01, 8'h66, 10, 14, 0, ba, bb, bz);
        frame(2'b10, 8'h40, 10, 1, 0, ba, bb, bz);
        frame(2'b11, 8'h00, 10, 12, 0, ba, bb, bz);
        check("done_ignored", ba, 8'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_slave.md
SPI_RAM_SLAVE -- requirements
Module: spi_ram_slave

Interface
REQ-001 SHALL have parameter W, default 8: word width of payload and memory data.
REQ-002 SHALL have parameter MEM_DEPTH, default 256: number of memory words; ADDR_W = $clog2(MEM_DEPTH), and ADDR_W <= W is required.
REQ-003 SHALL have port clk, input, 1: single clock; also the serial bit clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ss_n, input, 1: active-low frame select.
REQ-006 SHALL have port mosi, input, 1: serial data in, MSB first.
REQ-007 SHALL have port miso, output, 1: serial read data out, MSB first; 0 when not shifting.
REQ-008 SHALL have port busy, output, 1: high while a frame is in progress or a read is shifting out.

Function
REQ-009 A frame SHALL begin at the first rising edge sampling ss_n=0 in IDLE and SHALL consist of a 2-bit command followed by W payload bits, W+2 samples in total.
REQ-010 Command encoding SHALL be 00 = load write address, 01 = write data, 10 = load read address, 11 = read data.
REQ-011 FSM states SHALL be IDLE, RX, EXEC, TX and DONE: IDLE->RX on ss_n=0; RX->EXEC after W+2 bits; EXEC->TX for cmd 11, else EXEC->DONE; TX->DONE after W bits; DONE->IDLE on ss_n=1.
REQ-012 Address loads SHALL take the payload's low ADDR_W bits into wr_addr or rd_addr at the EXEC edge.
REQ-013 For cmd 01, the memory SHALL be written with the payload at wr_addr at the EXEC edge (edge k+1, where k is the last-bit edge).
REQ-014 For cmd 11, the memory word at rd_addr SHALL be loaded into the tx shifter at the EXEC edge; miso SHALL present bit W-1 after edge k+1, then one bit per edge, for W bits total.
REQ-015 Writes to an address >= MEM_DEPTH SHALL be dropped, and reads from such an address SHALL return all zeros.
REQ-016 If ss_n goes high before the frame completes, the FSM SHALL return to IDLE on that edge, discard partial bits, perform no memory or address update, and force miso to 0.
REQ-017 Bits received in DONE SHALL be ignored until ss_n=1.
REQ-018 If ss_n goes high during TX, TX SHALL abort, miso SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-019 busy SHALL be 0 only in IDLE.

Reset
REQ-020 On rst=1 at an edge, the FSM SHALL enter IDLE and wr_addr, rd_addr, the shifters and the bit counter SHALL clear; miso=0 and busy=0 thereafter.
REQ-021 Memory contents SHALL NOT be reset.
REQ-022 rst SHALL take priority over any frame in progress, including mid-TX.

Configuration
REQ-023 With SPI_RAM_AUTOINC_EN defined, wr_addr SHALL increment after each cmd-01 write and rd_addr after each cmd-11 load, wrapping from MEM_DEPTH-1 to 0.
REQ-024 Without SPI_RAM_AUTOINC_EN, addresses SHALL change only on cmd 00/10 or reset.
REQ-025 An aborted frame SHALL never increment an address.

Structure
REQ-026 Package spi_ram_pkg SHALL hold the command enum (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the state enum.
REQ-027 Sub-module spi_ram_mem SHALL be a parametrised single-port synchronous RAM (W x MEM_DEPTH) with one-cycle read latency.

Verification (W=8, MEM_DEPTH=256)
REQ-028 Send 00_0x12 then 01_0xA5 -> mem[0x12]=0xA5 after edge k+1.
REQ-029 Send 10_0x12 then 11_0x00 with ss_n held low -> miso = 1,0,1,0,0,1,0,1 on the 8 edges after k+1, then 0.
REQ-030 With AUTOINC, wr_addr=0xFF: write 0x11 then 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; without AUTOINC -> mem[0xFF]=0x22.
REQ-031 Raise ss_n after 5 bits of 01_0xFF -> no memory change, FSM IDLE, busy=0 next edge.
REQ-032 Assert rst during the 3rd TX bit -> miso=0 and busy=0 after that edge, and rd_addr=0.
REQ-033 With MEM_DEPTH=200, write to 0xD0 then read it back -> write dropped, read returns 0x00.
